// File: rtl/fft_iter_pkg.sv
// -----------------------------------------------------------------------------
// fft_iter_pkg
// Definitions shared by the iterative FFT control blocks (engine control unit
// and result unloader).
//   FFT_LAYERS / FFT_N : default stage count and point count (N = 2^LAYERS)
//   fft_state_t        : IDLE / READ / DRAIN state encoding (2-bit)
//   bit_rev()          : reverses the low 'width' bits of a value
// -----------------------------------------------------------------------------
package fft_iter_pkg;

   localparam int FFT_LAYERS     = 5;
   localparam int FFT_N          = 1 << FFT_LAYERS;
   localparam int BIT_REV_MAX_WL = 16;
   localparam int BIT_REV_IDX_WL = $clog2(BIT_REV_MAX_WL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } fft_state_t;

   // Bits at and above 'width' come back as zero; width must not exceed
   // BIT_REV_MAX_WL.
   function automatic logic [BIT_REV_MAX_WL-1:0] bit_rev(
      input logic [BIT_REV_MAX_WL-1:0] value,
      input int                        width
   );
      logic [BIT_REV_MAX_WL-1:0] result;
      result = '0;
      for (int i = 0; i < BIT_REV_MAX_WL; i++) begin
         if (i < width) begin
            result[BIT_REV_IDX_WL'(i)] = value[BIT_REV_IDX_WL'(width - 1 - i)];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fft_out_skid_fifo.sv
// -----------------------------------------------------------------------------
// fft_out_skid_fifo
// Two-entry FIFO with a registered head, used as the output skid buffer of the
// FFT unloader. Push and pop may coincide at any occupancy.
//   CLK, RST   : clock, asynchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : word to store ({last, data} in the unloader)
//   pop        : consume the head this cycle (only while occ != 0)
//   head       : oldest stored word, straight from a register
//   occ        : number of stored words, 0..2
// -----------------------------------------------------------------------------
module fft_out_skid_fifo #(
   parameter int WL = 33
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          push,
   input  logic [WL-1:0] push_data,
   input  logic          pop,
   output logic [WL-1:0] head,
   output logic [1:0]    occ
);

   logic [WL-1:0] tail;

   // NOTE: the storage registers are reset as well, because head drives the
   // block output directly and must read zero out of reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head <= '0;
         tail <= '0;
         occ  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) head <= push_data;
               else             tail <= push_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               // Full: shift tail into head and refill tail. Otherwise the
               // single stored word leaves and the new one becomes head.
               if (occ == 2'd2) begin
                  head <= tail;
                  tail <= push_data;
               end else begin
                  head <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   // The unloader's issue rule keeps a third word from ever arriving.
   a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
      !(push && !pop && occ == 2'd2));

endmodule

// File: rtl/fft_iter_unloader.sv
// -----------------------------------------------------------------------------
// fft_iter_unloader
// Read-out side of the iterative in-place FFT. After DONE from the butterfly
// engine it reads all N = 2^LAYERS words from the working RAM (optionally at
// bit-reversed addresses, giving natural frequency order) and streams them out
// over valid/ready. BUSY locks the engine out until the last word is taken.
//   CLK, RST     : clock, asynchronous active-high reset
//   EN           : low pauses new RAM reads; the output side keeps running
//   DONE         : one-cycle pulse from the engine, honoured only in IDLE
//   BUSY         : high from DONE acceptance until the last word is accepted
//   RD_EN/RD_ADDR: RAM read strobe and address
//   RD_DATA      : RAM data, valid one cycle after RD_EN
//   OUT_DATA/OUT_VALID/OUT_READY/OUT_LAST : output stream, OUT_LAST on word N-1
//   UNLOAD_DONE  : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module fft_iter_unloader
   import fft_iter_pkg::*;
#(
   parameter int LAYERS  = 5,
   parameter int ADDR_WL = 5,
   parameter int DATA_WL = 32,
   parameter bit BIT_REV = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               DONE,
   output logic               BUSY,
   output logic               RD_EN,
   output logic [ADDR_WL-1:0] RD_ADDR,
   input  logic [DATA_WL-1:0] RD_DATA,
   output logic [DATA_WL-1:0] OUT_DATA,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic               OUT_LAST,
   output logic               UNLOAD_DONE
);

   localparam logic [ADDR_WL-1:0] LAST_IDX = ADDR_WL'((1 << LAYERS) - 1);

   fft_state_t         state;
   logic [ADDR_WL-1:0] rd_cnt;
   logic               inflight;
   logic               inflight_last;
   logic               pop;
   logic [1:0]         occ;
   logic [DATA_WL:0]   head;

   assign pop                 = OUT_VALID & OUT_READY;
   assign OUT_VALID           = (occ != 2'd0);
   assign {OUT_LAST, OUT_DATA} = head;

   // A read may issue only if the words already committed to the buffer
   // (stored + landing next cycle - leaving now) leave room for it.
   assign RD_EN = (state == READ) && EN &&
                  (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   if (BIT_REV) begin : g_rev_addr
      assign RD_ADDR = ADDR_WL'(bit_rev(BIT_REV_MAX_WL'(rd_cnt), ADDR_WL));
   end else begin : g_lin_addr
      assign RD_ADDR = rd_cnt;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= IDLE;
         rd_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         BUSY          <= 1'b0;
         UNLOAD_DONE   <= 1'b0;
      end else begin
         inflight      <= RD_EN;
         inflight_last <= RD_EN && (rd_cnt == LAST_IDX);
         UNLOAD_DONE   <= 1'b0;
         if (RD_EN) rd_cnt <= rd_cnt + ADDR_WL'(1);

         case (state)
            IDLE: begin
               if (DONE) begin
                  state  <= READ;
                  rd_cnt <= '0;
                  BUSY   <= 1'b1;
               end
            end
            READ: begin
               // Leave on the last issue, so the counter wrap never re-reads.
               if (RD_EN && (rd_cnt == LAST_IDX)) state <= DRAIN;
            end
            DRAIN: begin
               if (pop && OUT_LAST) begin
                  state       <= IDLE;
                  BUSY        <= 1'b0;
                  UNLOAD_DONE <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fft_out_skid_fifo #(
      .WL(DATA_WL + 1)
   ) u_skid (
      .CLK      (CLK),
      .RST      (RST),
      .push     (inflight),
      .push_data({inflight_last, RD_DATA}),
      .pop      (pop),
      .head     (head),
      .occ      (occ)
   );

endmodule

// File: tb/tb_fft_iter_unloader.sv
// -----------------------------------------------------------------------------
// tb_fft_iter_unloader
// Bench for fft_iter_unloader: a bit-reversing instance checked every cycle
// against a stream model (expected word k = RAM[rev(k)], read k at rev(k),
// never more than two words committed), plus a linear-address instance.
// -----------------------------------------------------------------------------
module tb_fft_iter_unloader;

   localparam int LAYERS = 5;
   localparam int N      = 32;
   localparam int DW     = 32;

   logic          CLK, RST, EN, DONE, OUT_READY;
   logic          BUSY, RD_EN, OUT_VALID, OUT_LAST, UNLOAD_DONE;
   logic [4:0]    RD_ADDR;
   logic [DW-1:0] RD_DATA, OUT_DATA;

   logic          done_l, busy_l, rd_en_l, out_valid_l, out_last_l, ud_l;
   logic [4:0]    rd_addr_l;
   logic [DW-1:0] rd_data_l, out_data_l;

   logic [DW-1:0] ram [N];
   logic [DW-1:0] first_words [5];
   int            n_checks, n_fail;
   int            m_pops, m_reads, m_ud;

   fft_iter_unloader #(.LAYERS(LAYERS), .ADDR_WL(5), .DATA_WL(DW), .BIT_REV(1'b1)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .DONE(DONE), .BUSY(BUSY),
      .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
      .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_LAST(OUT_LAST), .UNLOAD_DONE(UNLOAD_DONE)
   );

   fft_iter_unloader #(.LAYERS(LAYERS), .ADDR_WL(5), .DATA_WL(DW), .BIT_REV(1'b0)) dut_lin (
      .CLK(CLK), .RST(RST), .EN(EN), .DONE(done_l), .BUSY(busy_l),
      .RD_EN(rd_en_l), .RD_ADDR(rd_addr_l), .RD_DATA(rd_data_l),
      .OUT_DATA(out_data_l), .OUT_VALID(out_valid_l), .OUT_READY(OUT_READY),
      .OUT_LAST(out_last_l), .UNLOAD_DONE(ud_l)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Synchronous-read working RAM, one port per instance.
   initial begin
      RD_DATA   = '0;
      rd_data_l = '0;
   end
   always @(posedge CLK) if (RD_EN)   RD_DATA   <= ram[RD_ADDR];
   always @(posedge CLK) if (rd_en_l) rd_data_l <= ram[rd_addr_l];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reverse the low LAYERS bits by shifting them out LSB-first into a new word.
   function automatic int rev(input int k);
      int r;
      r = 0;
      for (int b = 0; b < LAYERS; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   // Stream model of the bit-reversing instance, sampled on every falling edge.
   task automatic monitor();
      logic          stall_q;
      logic [DW-1:0] stall_data;
      logic          stall_last;
      int            outstanding;
      stall_q    = 1'b0;
      stall_data = '0;
      stall_last = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            m_pops  = 0;
            m_reads = 0;
            m_ud    = 0;
            stall_q = 1'b0;
         end else begin
            if (DONE && !BUSY) begin
               m_pops  = 0;
               m_reads = 0;
               m_ud    = 0;
            end
            if (stall_q) begin
               check("stall_valid", OUT_VALID, 1'b1);
               check("stall_data", OUT_DATA, stall_data);
               check("stall_last", OUT_LAST, stall_last);
            end
            outstanding = m_reads - m_pops - int'(OUT_VALID && OUT_READY);
            if (RD_EN) begin
               check("rd_room", outstanding < 2, 1'b1);
               check("rd_addr", RD_ADDR, rev(m_reads));
               check("rd_count", m_reads < N, 1'b1);
               m_reads++;
            end
            if (OUT_VALID && OUT_READY) begin
               check("out_data", OUT_DATA, ram[rev(m_pops)]);
               check("out_last", OUT_LAST, m_pops == N - 1);
               m_pops++;
            end
            if (UNLOAD_DONE) m_ud++;
            stall_q    = OUT_VALID && !OUT_READY;
            stall_data = OUT_DATA;
            stall_last = OUT_LAST;
         end
      end
   endtask

   // One unload on the bit-reversing instance. Period k = 0 is the cycle right
   // after the edge that accepts DONE.
   task automatic run(input int ready_mode, input int en_pause_at, input int abort_at,
                      input bit done_again, output int busy_cnt, output int first_k,
                      output int last_k, output int ud_k);
      int pops, reads, pause_left;
      bit aborted;
      pops = 0; reads = 0; pause_left = 0; aborted = 1'b0;
      busy_cnt = 0; first_k = -1; last_k = -1; ud_k = -1;
      DONE = 1'b1;
      @(posedge CLK); #1;
      DONE = 1'b0;
      for (int k = 0; k < 400 && ud_k < 0 && !aborted; k++) begin
         if (abort_at > 0 && pops == abort_at) begin
            RST = 1'b1;
            #1;
            check("abort_valid", OUT_VALID, 1'b0);
            check("abort_busy", BUSY, 1'b0);
            check("abort_rd_en", RD_EN, 1'b0);
            check("abort_data", OUT_DATA, '0);
            @(negedge CLK);
            @(posedge CLK); #1;
            RST = 1'b0;
            aborted = 1'b1;
         end else begin
            OUT_READY = (ready_mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            EN = (pause_left == 0);
            if (pause_left > 0) pause_left--;
            DONE = done_again && (k == 5 || k == 33);
            @(negedge CLK);
            if (BUSY) busy_cnt++;
            if (OUT_VALID && first_k < 0) first_k = k;
            if (RD_EN) begin
               reads++;
               if (reads == en_pause_at) pause_left = 5;
            end
            if (OUT_VALID && OUT_READY) begin
               if (pops < 5) first_words[pops] = OUT_DATA;
               if (OUT_LAST) last_k = k;
               pops++;
            end
            if (UNLOAD_DONE) ud_k = k;
            @(posedge CLK); #1;
         end
      end
      if (!aborted) check("unload_seen", ud_k >= 0, 1'b1);
      DONE = 1'b0; EN = 1'b1; OUT_READY = 1'b1;
   endtask

   initial begin
      int busy_cnt, first_k, last_k, ud_k, cnt, lin_first;
      n_checks = 0; n_fail = 0;
      m_pops = 0; m_reads = 0; m_ud = 0;
      RST = 1'b1; EN = 1'b1; DONE = 1'b0; done_l = 1'b0; OUT_READY = 1'b1;
      for (int i = 0; i < N; i++) ram[i] = DW'(i);

      // Reset values
      @(negedge CLK);
      check("rst_busy", BUSY, 1'b0);
      check("rst_rd_en", RD_EN, 1'b0);
      check("rst_rd_addr", RD_ADDR, 5'd0);
      check("rst_valid", OUT_VALID, 1'b0);
      check("rst_last", OUT_LAST, 1'b0);
      check("rst_data", OUT_DATA, '0);
      check("rst_unload_done", UNLOAD_DONE, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0;
      fork monitor(); join_none
      @(posedge CLK); #1;

      // Full-rate bit-reversed unload: timing and first words pinned by hand
      run(0, 0, 0, 1'b0, busy_cnt, first_k, last_k, ud_k);
      check("r1_busy_cycles", busy_cnt, 34);
      check("r1_first_valid", first_k, 2);
      check("r1_last_accept", last_k, 33);
      check("r1_unload_done", ud_k, 34);
      check("r1_words", m_pops, N);
      check("r1_reads", m_reads, N);
      check("r1_ud_pulses", m_ud, 1);
      check("r1_word0", first_words[0], 32'd0);
      check("r1_word1", first_words[1], 32'd16);
      check("r1_word2", first_words[2], 32'd8);
      check("r1_word3", first_words[3], 32'd24);
      check("r1_word4", first_words[4], 32'd4);
      @(posedge CLK); #1;

      // Linear-address instance: natural order, no gaps after the first word
      done_l = 1'b1;
      @(posedge CLK); #1;
      done_l = 1'b0;
      cnt = 0; lin_first = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (lin_first >= 0 && cnt < N) check("lin_no_gap", out_valid_l, 1'b1);
         if (out_valid_l) begin
            if (lin_first < 0) lin_first = k;
            check("lin_data", out_data_l, ram[cnt % N]);
            check("lin_last", out_last_l, cnt == N - 1);
            cnt++;
         end
         @(posedge CLK); #1;
      end
      check("lin_first_valid", lin_first, 2);
      check("lin_words", cnt, N);
      check("lin_busy_end", busy_l, 1'b0);

      // Backpressure 1,0,0,1 repeating
      for (int i = 0; i < N; i++) ram[i] = 32'h5A00_0000 + DW'(i * 3);
      run(1, 0, 0, 1'b0, busy_cnt, first_k, last_k, ud_k);
      check("bp_words", m_pops, N);
      check("bp_reads", m_reads, N);
      check("bp_ud_pulses", m_ud, 1);

      // EN low for 5 cycles after the 10th read
      run(0, 10, 0, 1'b0, busy_cnt, first_k, last_k, ud_k);
      check("en_words", m_pops, N);
      check("en_reads", m_reads, N);
      check("en_busy_cycles", busy_cnt, 39);

      // Reset after word 12, then a clean restart from address 0
      run(0, 0, 12, 1'b0, busy_cnt, first_k, last_k, ud_k);
      repeat (3) begin
         @(negedge CLK);
         check("abort_idle_busy", BUSY, 1'b0);
         check("abort_idle_valid", OUT_VALID, 1'b0);
      end
      check("abort_no_ud", m_ud, 0);
      @(posedge CLK); #1;
      run(0, 0, 0, 1'b0, busy_cnt, first_k, last_k, ud_k);
      check("restart_words", m_pops, N);
      check("restart_busy_cycles", busy_cnt, 34);
      check("restart_unload_done", ud_k, 34);

      // DONE pulses while BUSY must be ignored
      run(0, 0, 0, 1'b1, busy_cnt, first_k, last_k, ud_k);
      check("redone_words", m_pops, N);
      check("redone_reads", m_reads, N);
      check("redone_ud_pulses", m_ud, 1);
      check("redone_busy_cycles", busy_cnt, 34);
      repeat (4) @(posedge CLK);
      #1;
      check("redone_idle", BUSY, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_iter_unloader.md
Name: fft_iter_unloader

Overview:
- Read-out side of the iterative in-place FFT datapath.
- After the butterfly engine signals completion, it reads all 2^LAYERS complex results from the shared working RAM.
- It reorders them to natural frequency order by bit-reversing the read address, and streams them out over a valid/ready interface.
- It holds a lock so the engine cannot restart while results are still being drained.

Parameters:
- LAYERS, 5, number of FFT stages; N = 2^LAYERS points.
- ADDR_WL, 5, RAM address width; must equal LAYERS.
- DATA_WL, 32, width of one complex word: {re, im}, each DATA_WL/2 bits, passed through unmodified.
- BIT_REV, 1, 1 = read at bit-reversed address, 0 = linear address.

Ports:
- CLK  in  1  clock, all logic on posedge.
- RST  in  1  asynchronous reset, active-high.
- EN  in  1  when low, no new RAM reads are issued; the output side keeps running.
- DONE  in  1  one-cycle pulse from the engine at the end of the last layer.
- BUSY  out  1  high from the DONE acceptance until the last word is accepted; the engine gates START with !BUSY.
- RD_EN  out  1  RAM read strobe.
- RD_ADDR  out  ADDR_WL  RAM read address.
- RD_DATA  in  DATA_WL  RAM read data, valid exactly 1 cycle after RD_EN.
- OUT_DATA  out  DATA_WL  output sample.
- OUT_VALID  out  1  output valid.
- OUT_READY  in  1  downstream ready.
- OUT_LAST  out  1  high with sample index N-1.
- UNLOAD_DONE  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset values: BUSY=0, RD_EN=0, RD_ADDR=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, UNLOAD_DONE=0. The FSM resets to IDLE; read counter, in-flight flag and buffer are cleared.
- FSM states:
  - IDLE: DONE=1 moves to READ; read counter is cleared to 0 and BUSY goes high next cycle.
  - READ: issues reads. When the counter has issued index N-1, moves to DRAIN.
  - DRAIN: no reads issued. When the word flagged OUT_LAST is accepted (OUT_VALID & OUT_READY), returns to IDLE; BUSY falls and UNLOAD_DONE pulses in that same edge's following cycle.
- DONE is ignored in READ and DRAIN.
- Read issue rule: RD_EN = (state==READ) & EN & (occ + inflight - pop < 2).
  - occ = buffer occupancy (0..2).
  - inflight = RD_EN registered one cycle earlier.
  - pop = OUT_VALID & OUT_READY.
- RD_ADDR = bitrev(counter) when BIT_REV=1, else counter. The counter increments on each RD_EN.
- The last flag travels with each read: the read whose counter equals N-1 is tagged last.
- Buffer: 2-entry FIFO with a registered head.
  - Write: RD_DATA is written one cycle after RD_EN.
  - Read: OUT_VALID = occ!=0; OUT_DATA and OUT_LAST come from the head.
  - Push and pop in the same cycle are allowed at any occupancy, including occupancy 2.
  - The issue rule guarantees no overflow; an overflow is an assertion failure in simulation.
- Throughput: with OUT_READY held high and EN=1, one sample per cycle.
  - First OUT_VALID appears 2 cycles after DONE.
  - The last sample is accepted N+1 cycles after DONE.
- Backpressure: OUT_DATA and OUT_LAST stay stable while OUT_VALID=1 and OUT_READY=0. At most 2 words are buffered; reads stall accordingly.
- EN low mid-read: issuing pauses. The already in-flight read still lands in the buffer, and issuing resumes at the same counter.
- RST asserted mid-operation: outputs return to reset values immediately. Partial results are discarded; no UNLOAD_DONE is generated.
- Wrap: the counter is ADDR_WL bits; N-1 is detected before wrap, so no address is read twice.

Decomposition:
- Shared package fft_iter_pkg:
  - FSM state constants (IDLE, READ, DRAIN, 2-bit).
  - Bit-reverse function parameterised by width.
  - The N = 2^LAYERS constant.
  - The same package also serves the engine control unit.
- Sub-module fft_out_skid_fifo: 2-entry FIFO, DATA_WL+1 bits wide (data + last), push/pop/occ interface.

Test Plan:
- DONE pulse, OUT_READY=1, EN=1, RAM[i]=i, N=32 -> OUT_DATA sequence 0,16,8,24,4,... (bitrev order); OUT_LAST on the 32nd word; UNLOAD_DONE one cycle after; BUSY high for exactly 34 cycles.
- BIT_REV=0, same stimulus -> OUT_DATA 0..31 in order, one per cycle, no gaps after the first.
- OUT_READY toggled 1,0,0,1 repeating -> no sample lost or duplicated; OUT_DATA stable during stalls; RD_EN never issued while occ+inflight-pop=2.
- EN=0 for 5 cycles after the 10th read -> reads resume at counter 10; full 32-word output is correct.
- RST asserted at word 12 -> OUT_VALID=0 and BUSY=0 immediately; next DONE restarts from address 0 with correct data.
- DONE pulses again while BUSY=1 -> ignored; exactly 32 words are produced.
